mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between the
// instruction-fetch and data ports, one transaction at a time, round-robin.
module mem_port_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADR_W  = 12,
    parameter int SEL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifetch_read,
    input  logic [ADR_W-1:0]  ifetch_address,
    output logic [LINE_W-1:0] ifetch_rdata,
    output logic              ifetch_resp,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADR_W-1:0]  mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_sel,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADR_W-1:0]  pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic [SEL_W-1:0]  pmem_sel,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [31:0]       grant_count_i,
    output logic [31:0]       grant_count_d,
    output logic [31:0]       conflict_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_d;
    logic                r_read;
    logic                r_write;
    logic [ADR_W-1:0]    r_address;
    logic [LINE_W-1:0]   r_wdata;
    logic [SEL_W-1:0]    r_sel;
    logic [31:0]         r_cnt_i;
    logic [31:0]         r_cnt_d;
    logic [31:0]         r_cnt_c;

    logic w_req_i;
    logic w_req_d;
    logic w_pick_d;

    assign w_req_i  = ifetch_read;
    assign w_req_d  = mem_read | mem_write;
    // A tie goes to the side that was not granted last.
    assign w_pick_d = w_req_d & (~w_req_i | ~r_last_d);

    // Arbitration FSM: grant in IDLE, hold latched fields until pmem_resp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_cnt_i   <= '0;
            r_cnt_d   <= '0;
            r_cnt_c   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_i && w_req_d) begin
                        r_cnt_c <= r_cnt_c + 32'd1;
                    end
                    if (w_pick_d) begin
                        r_state   <= SERVE_D;
                        r_last_d  <= 1'b1;
                        r_cnt_d   <= r_cnt_d + 32'd1;
                        r_address <= mem_address;
                        r_wdata   <= mem_wdata;
                        r_sel     <= mem_sel;
                        r_write   <= mem_write;
                        r_read    <= mem_read & ~mem_write;
                    end else if (w_req_i) begin
                        r_state   <= SERVE_I;
                        r_last_d  <= 1'b0;
                        r_cnt_i   <= r_cnt_i + 32'd1;
                        r_address <= ifetch_address;
                        r_wdata   <= '0;
                        r_sel     <= '0;
                        r_write   <= 1'b0;
                        r_read    <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state <= IDLE;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read      = r_read;
    assign pmem_write     = r_write;
    assign pmem_address   = r_address;
    assign pmem_wdata     = r_wdata;
    assign pmem_sel       = r_sel;
    assign ifetch_rdata   = pmem_rdata;
    assign mem_rdata      = pmem_rdata;
    assign ifetch_resp    = pmem_resp & (r_state == SERVE_I);
    assign mem_resp       = pmem_resp & (r_state == SERVE_D);
    assign grant_count_i  = r_cnt_i;
    assign grant_count_d  = r_cnt_d;
    assign conflict_count = r_cnt_c;

endmodule
